wb_regs: RTL and testbench

- Write-back stage and integer register file directly downstream of the execute stage.
- Registers the execute-stage result (rd address, data, write enable) for one cycle, then commits it to a 32x32 register file.
- Supplies two combinational read ports to decode, with full bypass from the execute outputs and from the write-back register. Decode never sees stale data.
- x0 is hardwired to zero.

---
 rtl/wb_regs.sv | 97 +++++++++
 tb/tb_wb_regs.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wb_regs.sv
// rtl/wb_regs.sv - write-back register and 32x32 integer register file with full read bypass
// Optional debug read port and retire counter under `define WB_REGS_DEBUG_PORT_EN
module wb_regs #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              reg_wen_i,
    input  logic [ADDR_W-1:0] rs1_raddr_i,
    input  logic [ADDR_W-1:0] rs2_raddr_i,
    output logic [DATA_W-1:0] rs1_rdata_o,
    output logic [DATA_W-1:0] rs2_rdata_o,
`ifdef WB_REGS_DEBUG_PORT_EN
    input  logic [ADDR_W-1:0] dbg_raddr_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic [31:0]       retire_cnt_o,
`endif
    output logic              wb_valid_o,
    output logic [ADDR_W-1:0] wb_addr_o
);

    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_wen;
    logic [DATA_W-1:0] regs [REG_NUM];

    // x0 writes are dropped here so wb_wen never pairs with address 0
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_addr <= '0;
            wb_data <= '0;
            wb_wen  <= 1'b0;
        end else if (!hold_i) begin
            wb_addr <= rd_addr_i;
            wb_data <= rd_data_i;
            wb_wen  <= reg_wen_i && (rd_addr_i != '0);
        end
    end

    // Commit ignores hold_i: a held entry just rewrites the same value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_wen) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Execute result is younger than the write-back entry, so it wins
    always_comb begin
        rs1_rdata_o = regs[rs1_raddr_i];
        if (rst || rs1_raddr_i == '0) begin
            rs1_rdata_o = '0;
        end else if (reg_wen_i && rd_addr_i == rs1_raddr_i) begin
            rs1_rdata_o = rd_data_i;
        end else if (wb_wen && wb_addr == rs1_raddr_i) begin
            rs1_rdata_o = wb_data;
        end
    end

    always_comb begin
        rs2_rdata_o = regs[rs2_raddr_i];
        if (rst || rs2_raddr_i == '0) begin
            rs2_rdata_o = '0;
        end else if (reg_wen_i && rd_addr_i == rs2_raddr_i) begin
            rs2_rdata_o = rd_data_i;
        end else if (wb_wen && wb_addr == rs2_raddr_i) begin
            rs2_rdata_o = wb_data;
        end
    end

    assign wb_valid_o = wb_wen;
    assign wb_addr_o  = wb_addr;

`ifdef WB_REGS_DEBUG_PORT_EN
    logic [31:0] retire_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (wb_wen && !hold_i) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign retire_cnt_o = retire_cnt;
    assign dbg_rdata_o  = (rst || dbg_raddr_i == '0) ? '0 : regs[dbg_raddr_i];
`endif

endmodule

// File: tb/tb_wb_regs.sv
// tb/tb_wb_regs.sv - directed self-checking bench for wb_regs
module tb_wb_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        reg_wen_i;
    logic [4:0]  rs1_raddr_i;
    logic [4:0]  rs2_raddr_i;
    logic [31:0] rs1_rdata_o;
    logic [31:0] rs2_rdata_o;
    logic        wb_valid_o;
    logic [4:0]  wb_addr_o;
`ifdef WB_REGS_DEBUG_PORT_EN
    logic [4:0]  dbg_raddr_i;
    logic [31:0] dbg_rdata_o;
    logic [31:0] retire_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    wb_regs dut (
        .clk         (clk),
        .rst         (rst),
        .hold_i      (hold_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_i   (rd_data_i),
        .reg_wen_i   (reg_wen_i),
        .rs1_raddr_i (rs1_raddr_i),
        .rs2_raddr_i (rs2_raddr_i),
        .rs1_rdata_o (rs1_rdata_o),
        .rs2_rdata_o (rs2_rdata_o),
`ifdef WB_REGS_DEBUG_PORT_EN
        .dbg_raddr_i (dbg_raddr_i),
        .dbg_rdata_o (dbg_rdata_o),
        .retire_cnt_o(retire_cnt_o),
`endif
        .wb_valid_o  (wb_valid_o),
        .wb_addr_o   (wb_addr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic wen, input logic [4:0] addr, input logic [31:0] data);
        reg_wen_i = wen;
        rd_addr_i = addr;
        rd_data_i = data;
        #1;
    endtask

    initial begin
        rst = 1'b1; hold_i = 1'b0;
        rs1_raddr_i = 5'd5; rs2_raddr_i = 5'd0;
`ifdef WB_REGS_DEBUG_PORT_EN
        dbg_raddr_i = 5'd0;
`endif
        ex(1'b1, 5'd5, 32'h1234);
        check("rst_rs1_bypass_masked", rs1_rdata_o, 32'h0);
        tick();
        check("rst_rs1_cycle2", rs1_rdata_o, 32'h0);
        tick();
        rst = 1'b0;
        ex(1'b0, 5'd0, 32'h0);
        check("post_rst_wb_valid", {31'h0, wb_valid_o}, 32'h0);
        check("post_rst_wb_addr", {27'h0, wb_addr_o}, 32'h0);
        check("post_rst_x5", rs1_rdata_o, 32'h0);

        // Basic write: ex bypass, wb bypass, then array
        rs1_raddr_i = 5'd3; rs2_raddr_i = 5'd3;
        ex(1'b1, 5'd3, 32'hDEAD_BEEF);
        check("x3_ex_bypass", rs1_rdata_o, 32'hDEAD_BEEF);
        check("x3_ex_bypass_rs2", rs2_rdata_o, 32'hDEAD_BEEF);
        tick();
        ex(1'b0, 5'd0, 32'h0);
        check("x3_wb_bypass", rs1_rdata_o, 32'hDEAD_BEEF);
        check("x3_wb_valid", {31'h0, wb_valid_o}, 32'h1);
        check("x3_wb_addr", {27'h0, wb_addr_o}, 32'd3);
        tick();
        check("x3_array", rs1_rdata_o, 32'hDEAD_BEEF);
        check("x3_array_rs2", rs2_rdata_o, 32'hDEAD_BEEF);
        check("x3_wb_idle", {31'h0, wb_valid_o}, 32'h0);

        // Ex result beats older wb entry for the same register
        rs2_raddr_i = 5'd7;
        ex(1'b1, 5'd7, 32'h11);
        tick();
        ex(1'b1, 5'd7, 32'h22);
        check("x7_ex_over_wb", rs2_rdata_o, 32'h22);
        tick();
        ex(1'b0, 5'd0, 32'h0);
        check("x7_wb", rs2_rdata_o, 32'h22);
        tick();
        check("x7_array", rs2_rdata_o, 32'h22);

        // x0 writes are dropped
        rs1_raddr_i = 5'd0;
        ex(1'b1, 5'd0, 32'hFFFF_FFFF);
        check("x0_ex", rs1_rdata_o, 32'h0);
        tick();
        ex(1'b0, 5'd0, 32'h0);
        check("x0_wb_valid", {31'h0, wb_valid_o}, 32'h0);
        check("x0_wb", rs1_rdata_o, 32'h0);
        tick();
        check("x0_array", rs1_rdata_o, 32'h0);

        // Hold freezes the wb register
        rs1_raddr_i = 5'd9;
        ex(1'b1, 5'd9, 32'hA5);
        tick();
        hold_i = 1'b1;
        ex(1'b0, 5'd9, 32'h5A);
        for (int i = 0; i < 3; i++) begin
            check("hold_wb_valid", {31'h0, wb_valid_o}, 32'h1);
            check("hold_wb_addr", {27'h0, wb_addr_o}, 32'd9);
            check("hold_x9", rs1_rdata_o, 32'hA5);
            tick();
        end
        hold_i = 1'b0;
        #1;
        check("hold_release_x9", rs1_rdata_o, 32'hA5);
        tick();
        check("hold_after_x9", rs1_rdata_o, 32'hA5);
        check("hold_after_valid", {31'h0, wb_valid_o}, 32'h0);

        // Reset mid-operation drops the pending write and clears the array
        rs1_raddr_i = 5'd12; rs2_raddr_i = 5'd3;
        ex(1'b1, 5'd12, 32'h77);
        tick();
        ex(1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_x12", rs1_rdata_o, 32'h0);
        check("midrst_x3", rs2_rdata_o, 32'h0);
        check("midrst_valid", {31'h0, wb_valid_o}, 32'h0);
        tick();
        check("midrst_x12_later", rs1_rdata_o, 32'h0);

`ifdef WB_REGS_DEBUG_PORT_EN
        check("cnt_reset", retire_cnt_o, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            ex(1'b1, 5'(i + 16), 32'h100 + 32'(i));
            tick();
        end
        ex(1'b0, 5'd0, 32'h0);
        dbg_raddr_i = 5'd20;
        #1;
        check("dbg_before_commit", dbg_rdata_o, 32'h0);
        check("cnt_three", retire_cnt_o, 32'd3);
        tick();
        check("dbg_after_commit", dbg_rdata_o, 32'h104);
        check("cnt_four", retire_cnt_o, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
